// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: parametrised inter-stage pipeline register chain
//   (DEPTH slots) with per-slot valid, stall hold, flush squash and a
//   saturating stall counter.
// Latency: exactly DEPTH clk cycles from DataIn to Buffer when not stalled.
// Backpressure: stall=1 freezes every slot, flush=1 squashes every slot;
//   flush has priority over stall.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   stall        hold all slots this cycle
//   flush        squash all slots this cycle (valid cleared, CTRL_MASK bits zeroed)
//   valid_in     DataIn carries a real instruction
//   DataIn       packed word from the producing stage
//   Buffer       packed word of the last slot
//   valid_out    last slot holds a real instruction
//   stall_count  stall cycles (stall=1, flush=0) since reset, saturating
//   occupancy    number of slots with valid=1
module pipe_stage_buffer #(
    parameter int               WIDTH     = 91,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] CTRL_MASK = {WIDTH{1'b0}},
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] DataIn,
    output logic [WIDTH-1:0] Buffer,
    output logic             valid_out,
    output logic [CNT_W-1:0] stall_count,
    output logic [2:0]       occupancy
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("pipe_stage_buffer: DEPTH must be in 1..4");
        end
    endgenerate

    logic [WIDTH-1:0] slot_data [DEPTH];
    logic [DEPTH-1:0] slot_vld;

    // A bubble entering slot 0 carries the producer's data bits but never
    // its control bits, so a slot with valid=0 can never trigger a side
    // effect downstream even if a consumer forgets to qualify with valid.
    logic [WIDTH-1:0] entry_data;
    assign entry_data = valid_in ? DataIn : (DataIn & ~CTRL_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_data[i] <= '0;
            end
            slot_vld <= '0;
        end else if (flush) begin
            // Squash in place: only control bits are cleared, the rest of
            // the word is left as-is (useful for debug visibility).
            for (int i = 0; i < DEPTH; i++) begin
                slot_data[i] <= slot_data[i] & ~CTRL_MASK;
            end
            slot_vld <= '0;
        end else if (!stall) begin
            slot_data[0] <= entry_data;
            slot_vld[0]  <= valid_in;
            for (int i = 1; i < DEPTH; i++) begin
                slot_data[i] <= slot_data[i-1];
                slot_vld[i]  <= slot_vld[i-1];
            end
        end
    end

    // Flush outranks stall, so a cycle with both is not counted as a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && !flush && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign Buffer    = slot_data[DEPTH-1];
    assign valid_out = slot_vld[DEPTH-1];

    // Popcount of registered valids only; no input reaches this output.
    always_comb begin
        occupancy = 3'd0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + 3'(slot_vld[i]);
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
module tb_pipe_stage_buffer;

    localparam int W = 91;
    localparam logic [W-1:0] MASK    = 91'h0000_F000_0000_0000; // bits 47:44
    localparam logic [W-1:0] ONES    = {W{1'b1}};
    localparam logic [W-1:0] ONES_NM = ONES & ~MASK;
    localparam logic [W-1:0] ZERO    = '0;
    localparam logic [W-1:0] WA      = 91'h4000_0012_3401;      // bit 46 set
    localparam logic [W-1:0] WB      = 91'h4000_00AB_CD02;
    localparam logic [W-1:0] WC      = 91'h4000_0055_6603;
    localparam logic [W-1:0] WA_NM   = 91'h0000_0012_3401;
    localparam logic [W-1:0] WC_NM   = 91'h0000_0055_6603;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0;
    logic flush = 1'b0;
    logic valid_in = 1'b1;
    logic [W-1:0] data_in = ONES;

    logic [W-1:0] buf1, buf2, buf3;
    logic vo1, vo2, vo3;
    logic [15:0] cnt1, cnt3;
    logic [3:0] cnt2;
    logic [2:0] occ1, occ2, occ3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_buffer #(.WIDTH(W), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .DataIn(data_in), .Buffer(buf1), .valid_out(vo1), .stall_count(cnt1),
        .occupancy(occ1)
    );

    pipe_stage_buffer #(.WIDTH(W), .DEPTH(2), .CTRL_MASK(MASK), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .DataIn(data_in), .Buffer(buf2), .valid_out(vo2), .stall_count(cnt2),
        .occupancy(occ2)
    );

    pipe_stage_buffer #(.WIDTH(W), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .DataIn(data_in), .Buffer(buf3), .valid_out(vo3), .stall_count(cnt3),
        .occupancy(occ3)
    );

    typedef struct packed {
        logic         stall;
        logic         flush;
        logic         vin;
        logic [W-1:0] d;
        logic [W-1:0] eb;
        logic         ev;
        logic [3:0]   ec;
        logic [2:0]   eo;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] t2_buf [6];
        logic         t2_v   [6];
        logic [2:0]   t2_occ [6];

        // DEPTH=2, mask 47:44, CNT_W=4 sequence: load, stall, release, flush, bubble
        tbl[0]  = '{1'b0, 1'b0, 1'b1, WA,   ZERO,    1'b0, 4'd0, 3'd1};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, WB,   WA,      1'b1, 4'd0, 3'd2};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, WC,   WA,      1'b1, 4'd1, 3'd2};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, WC,   WA,      1'b1, 4'd2, 3'd2};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, WC,   WA,      1'b1, 4'd3, 3'd2};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, WC,   WA,      1'b1, 4'd4, 3'd2};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, WC,   WA,      1'b1, 4'd5, 3'd2};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, WC,   WB,      1'b1, 4'd5, 3'd2};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, WA,   WC,      1'b1, 4'd5, 3'd2};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, WB,   WC_NM,   1'b0, 4'd5, 3'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, WB,   WA_NM,   1'b0, 4'd5, 3'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, WC,   WB,      1'b1, 4'd5, 3'd2};
        tbl[12] = '{1'b0, 1'b0, 1'b0, ONES, WC,      1'b1, 4'd5, 3'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, ONES, ONES_NM, 1'b0, 4'd5, 3'd0};

        t2_buf = '{ZERO, ZERO, 91'd1, 91'd2, 91'd3, 91'd4};
        t2_v   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        t2_occ = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};

        // T1: reset held with clock running and all-ones valid input
        repeat (3) tick();
        chk("t1_rst_buf1", buf1, ZERO);
        chk("t1_rst_vo1", W'(vo1), W'(0));
        chk("t1_rst_cnt1", W'(cnt1), W'(0));
        chk("t1_rst_occ1", W'(occ1), W'(0));
        chk("t1_rst_buf3", buf3, ZERO);
        rst = 1'b0;
        tick();
        chk("t1_cap_buf1", buf1, ONES);
        chk("t1_cap_vo1", W'(vo1), W'(1));
        chk("t1_cap_occ1", W'(occ1), W'(1));

        // T2: DEPTH=3 latency and DEPTH=1 single-register latency
        pulse_rst();
        for (int k = 0; k < 6; k++) begin
            data_in = W'(k + 1);
            tick();
            chk($sformatf("t2_buf3_%0d", k), buf3, t2_buf[k]);
            chk($sformatf("t2_vo3_%0d", k), W'(vo3), W'(t2_v[k]));
            chk($sformatf("t2_occ3_%0d", k), W'(occ3), W'(t2_occ[k]));
            chk($sformatf("t2_buf1_%0d", k), buf1, W'(k + 1));
        end

        // T3..T5 on DEPTH=2 from the table
        pulse_rst();
        for (int r = 0; r < 14; r++) begin
            stall    = tbl[r].stall;
            flush    = tbl[r].flush;
            valid_in = tbl[r].vin;
            data_in  = tbl[r].d;
            tick();
            chk($sformatf("tbl_buf_%0d", r), buf2, tbl[r].eb);
            chk($sformatf("tbl_vo_%0d", r), W'(vo2), W'(tbl[r].ev));
            chk($sformatf("tbl_cnt_%0d", r), W'(cnt2), W'(tbl[r].ec));
            chk($sformatf("tbl_occ_%0d", r), W'(occ2), W'(tbl[r].eo));
        end

        // T6: saturation of the 4-bit counter (starts at 5 here)
        stall    = 1'b1;
        flush    = 1'b0;
        valid_in = 1'b1;
        data_in  = WA;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("t6_cnt2_%0d", k), W'(cnt2), (k < 10) ? W'(5 + k) : W'(15));
        end
        chk("t6_cnt1_nosat", W'(cnt1), W'(25));
        chk("t6_cnt3_nosat", W'(cnt3), W'(25));

        // Async reset pulse between edges, still stalling
        rst = 1'b1;
        #1;
        chk("t6_arst_cnt2", W'(cnt2), W'(0));
        chk("t6_arst_vo2", W'(vo2), W'(0));
        chk("t6_arst_occ2", W'(occ2), W'(0));
        chk("t6_arst_cnt1", W'(cnt1), W'(0));
        chk("t6_arst_vo1", W'(vo1), W'(0));
        #1;
        rst = 1'b0;
        tick();
        chk("t6_post_cnt2", W'(cnt2), W'(1));
        chk("t6_post_vo1", W'(vo1), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
